// File: rtl/octal_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// Registered one-hot grant plus binary index; grants are held until the
// owner releases, with an optional hold limit that forces rotation when
// other requesters are waiting.
module octal_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Value of the hold counter in the last cycle an owner may keep the grant
  // while others wait.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              preempt_q, preempt_d;
  logic [7:0]        gnt_q, gnt_d;

  logic [3:0]        pick_all;
  logic [3:0]        pick_oth;
  logic              own_req;

  // Rotating priority search: returns {found, index} of the first set bit
  // of cand, scanning start, start+1, ... modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] cand, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!res[3] && cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state logic: arbitration, release, hold counting and forced rotation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;

    pick_all = rr_pick(req, ptr_q);
    pick_oth = rr_pick(req & ~(8'b1 << owner_q), ptr_q);
    own_req  = req[owner_q];

    case (state_q)
      IDLE: begin
        if (en && pick_all[3]) begin
          state_d = GRANT;
          owner_d = pick_all[2:0];
          ptr_d   = pick_all[2:0] + 3'd1;
          hold_d  = '0;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (!own_req) begin
          if (en && pick_all[3]) begin
            owner_d = pick_all[2:0];
            ptr_d   = pick_all[2:0] + 3'd1;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            hold_d  = '0;
            valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          hold_d = '0;
          if (en && pick_oth[3]) begin
            owner_d   = pick_oth[2:0];
            ptr_d     = pick_oth[2:0] + 3'd1;
            preempt_d = 1'b1;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        hold_d  = '0;
        valid_d = 1'b0;
      end
    endcase

    gnt_d = valid_d ? (8'b1 << owner_d) : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = owner_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Scoreboard bench for octal_rr_arbiter: each stimulus cycle pushes the
// reference model's expected outputs; a monitor pops and compares them.
module tb_octal_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  octal_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       preempt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: owner -1 means nobody holds the resource.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  int   m_age   = 0;
  exp_t m_exp;

  function automatic int pick(input logic [7:0] cand, input int start);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (start + i) % 8;
      if (cand[k]) return k;
    end
    return -1;
  endfunction

  task automatic model(input logic r, input logic e, input logic [7:0] q);
    logic [7:0] others;
    int         w;
    bit         fresh;
    bit         pre;
    fresh = 0;
    pre   = 0;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = pick(q, m_ptr);
      if (e && w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % 8; m_hold = 0; fresh = 1;
      end
    end else if (!q[m_owner]) begin
      w = pick(q, m_ptr);
      if (e && w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % 8; m_hold = 0; fresh = 1;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end else if (MAXH != 0 && m_hold == MAXH - 1) begin
      others = q;
      others[m_owner] = 1'b0;
      w = pick(others, m_ptr);
      m_hold = 0;
      if (e && w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % 8; pre = 1; fresh = 1;
      end
    end else begin
      m_hold = (m_hold < 255) ? m_hold + 1 : 255;
    end
    if (m_owner < 0)  m_age = 0;
    else if (fresh)   m_age = 1;
    else              m_age = m_age + 1;
    m_exp.gnt     = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    m_exp.idx     = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    m_exp.valid   = (m_owner >= 0);
    m_exp.preempt = pre;
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] q);
    rst_n = r;
    en    = e;
    req   = q;
    model(r, e, q);
    @(posedge clk);
    exp_q.push_back(m_exp);
    #1;
  endtask

  // Monitor: one observation of the registered outputs per cycle.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {gnt, gnt_idx, gnt_valid, preempt};
        cyc++;
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL grant_cycle %0d: got gnt=%b idx=%0d valid=%b preempt=%b, expected gnt=%b idx=%0d valid=%b preempt=%b",
                   cyc, got.gnt, got.idx, got.valid, got.preempt,
                   e.gnt, e.idx, e.valid, e.preempt);
        end
      end
    end
  end

  initial begin
    logic [7:0] q;
    logic [7:0] rq;
    int         n;

    // Reset with all requests high, then idle after release.
    step(0, 1, 8'hFF);
    step(0, 1, 8'hFF);
    repeat (3) step(1, 1, 8'h00);

    // Basic one-cycle latency and release.
    step(1, 1, 8'b0000_0100);
    step(1, 1, 8'b0000_0100);
    step(1, 1, 8'h00);
    step(1, 1, 8'h00);

    // Fairness: everyone requests, each owner drops out after two cycles.
    step(0, 1, 8'h00);
    for (int i = 0; i < 22; i++) begin
      q = 8'hFF;
      if (m_owner >= 0 && m_age >= 2) q[m_owner] = 1'b0;
      step(1, 1, q);
    end

    // Wrap: owner 7 releases while 0 and 1 request; 0 must win.
    step(0, 1, 8'h00);
    step(1, 1, 8'b1000_0000);
    step(1, 1, 8'b1000_0011);
    step(1, 1, 8'b0000_0011);
    step(1, 1, 8'h00);

    // Hold limit with two contenders, then a lone requester.
    step(0, 1, 8'h00);
    repeat (14) step(1, 1, 8'b0000_0011);
    repeat (22) step(1, 1, 8'b0000_0001);
    step(1, 1, 8'h00);

    // Enable gating and reset while granted.
    step(0, 1, 8'h00);
    step(1, 1, 8'b0000_1000);
    repeat (3) step(1, 0, 8'b0010_1000);
    repeat (2) step(1, 0, 8'b0010_0000);
    step(1, 1, 8'b0010_0000);
    step(1, 1, 8'b0010_0000);
    step(0, 1, 8'b0010_0000);
    step(1, 1, 8'b0000_0110);
    step(1, 1, 8'b0000_0110);

    // Randomised traffic with persistent requests.
    rq = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 3);
      if (n == 0) rq = 8'($urandom) & 8'($urandom);
      else if (n == 1 && m_owner >= 0 && $urandom_range(0, 1) == 1) rq[m_owner] = 1'b0;
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), rq);
    end

    // Drain the scoreboard with a bounded wait.
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
